// File: rtl/inst_sram_fetch_ctrl.sv
// Shared-SRAM controller: IF fetches through a one-entry instruction buffer,
// MEM loads/stores arbitrated ahead of fetches, programmable wait states.
module inst_sram_fetch_ctrl #(
  parameter int unsigned        ADDR_W      = 16,
  parameter int unsigned        DATA_W      = 16,
  parameter int unsigned        SRAM_ADDR_W = 18,
  parameter int unsigned        WAIT_CYC    = 1,
  parameter logic [DATA_W-1:0]  NOP_WORD    = 16'h0800
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [ADDR_W-1:0]      if_addr,
  output logic [DATA_W-1:0]      if_data,
  output logic                   if_valid,
  output logic                   if_stall,
  input  logic                   mem_req,
  input  logic                   mem_we,
  input  logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_wdata,
  output logic [DATA_W-1:0]      mem_rdata,
  output logic                   mem_done,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0]      sram_wdata,
  output logic                   sram_dq_oe,
  input  logic [DATA_W-1:0]      sram_rdata,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n
);

  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, WR_REC} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  state_t              state, state_n;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   wdata_q;
  logic                buf_valid;
  logic [ADDR_W-1:0]   buf_addr;
  logic [DATA_W-1:0]   buf_data;
  logic                pulse, hit, last;

  // A completion pulse blocks arbitration for one cycle so requesters can drop
  assign pulse = if_valid | mem_done;
  assign hit   = if_req & buf_valid & (buf_addr == if_addr);
  assign last  = (cnt == 4'd0);

  assign if_stall   = if_req & ~if_valid;
  assign sram_addr  = {{(SRAM_ADDR_W-ADDR_W){1'b0}}, acc_addr};
  assign sram_wdata = wdata_q;

  always_comb begin
    state_n    = state;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    unique case (state)
      IDLE: begin
        if (!pulse) begin
          if (mem_req)             state_n = mem_we ? MEM_WR : MEM_RD;
          else if (if_req && !hit) state_n = IF_RD;
        end
      end
      IF_RD, MEM_RD: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        if (last) state_n = IDLE;
      end
      MEM_WR: begin
        sram_ce_n  = 1'b0;
        sram_we_n  = 1'b0;
        sram_dq_oe = 1'b1;
        if (last) state_n = WR_REC;
      end
      WR_REC: begin
        // strobe released, bus still driven for data hold time
        sram_ce_n  = 1'b0;
        sram_dq_oe = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      acc_addr  <= '0;
      wdata_q   <= '0;
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      if_data   <= NOP_WORD;
      if_valid  <= 1'b0;
      mem_rdata <= '0;
      mem_done  <= 1'b0;
    end else begin
      state    <= state_n;
      if_valid <= 1'b0;
      mem_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!pulse) begin
            cnt <= WAIT_LD;
            if (mem_req) begin
              acc_addr <= mem_addr;
              if (mem_we) begin
                wdata_q <= mem_wdata;
                if (buf_addr == mem_addr) buf_valid <= 1'b0;
              end
            end else if (hit) begin
              if_valid <= 1'b1;
              if_data  <= buf_data;
            end else if (if_req) begin
              acc_addr <= if_addr;
            end
          end
        end
        IF_RD: begin
          if (!last) cnt <= cnt - 4'd1;
          else begin
            // buffer fills even if the fetch was redirected meanwhile
            buf_valid <= 1'b1;
            buf_addr  <= acc_addr;
            buf_data  <= sram_rdata;
            if (if_addr == acc_addr) begin
              if_valid <= 1'b1;
              if_data  <= sram_rdata;
            end
          end
        end
        MEM_RD: begin
          if (!last) cnt <= cnt - 4'd1;
          else begin
            mem_rdata <= sram_rdata;
            mem_done  <= 1'b1;
          end
        end
        MEM_WR: begin
          if (!last) cnt <= cnt - 4'd1;
        end
        WR_REC: mem_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
